// File: rtl/maze_solver_ctrl_if.sv
// Control/status bundle between the maze-solver sequencer (master) and the
// datapath plus host side (slave).
interface maze_solver_ctrl_if;
   logic       start;
   logic       mem_blk;
   logic       end_pos;
   logic       s_empty;
   logic       cout;
   logic       queue_done;
   logic [1:0] dir_out;
   logic [1:0] sel;
   logic       ld;
   logic       rd;
   logic       wr;
   logic       push;
   logic       pop;
   logic       qshift;
   logic       show_move;
   logic       rst_xy;
   logic       rst_stack;
   logic       rst_queue;
   logic       busy;
   logic       done;
   logic       fail;

   modport master (
      input  start, mem_blk, end_pos, s_empty, cout, queue_done, dir_out,
      output sel, ld, rd, wr, push, pop, qshift, show_move, rst_xy, rst_stack, rst_queue,
             busy, done, fail
   );

   modport slave (
      output start, mem_blk, end_pos, s_empty, cout, queue_done, dir_out,
      input  sel, ld, rd, wr, push, pop, qshift, show_move, rst_xy, rst_stack, rst_queue,
             busy, done, fail
   );
endinterface

// File: rtl/maze_solver_ctrl.sv
// Sequencer for the maze-solver datapath: depth-first search from (0,0) to (15,15) with a
// direction stack, then a move-by-move replay of the found path through the queue port.
module maze_solver_ctrl #(
   parameter int unsigned STEP_LIMIT = 4096,
   parameter int unsigned SHOW_HOLD  = 1
) (
   input logic                clk,
   input logic                rst,
   maze_solver_ctrl_if.master bus
);
   localparam int unsigned StepW = $clog2(STEP_LIMIT) + 1;
   localparam int unsigned HoldW = (SHOW_HOLD > 1) ? $clog2(SHOW_HOLD) : 1;
   localparam logic [StepW-1:0] StepMax  = StepW'(STEP_LIMIT);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(SHOW_HOLD - 1);

   typedef enum logic [3:0] {
      StIdle, StInit, StMark, StCheck, StProbe, StAdvance, StNext, StBack, StBmove,
      StShowLd, StShowCur, StShowSh, StShowChk, StDone, StFail
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       dir_q, dir_d;
   logic [StepW-1:0] steps_q, steps_d, steps_inc;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             limit_hit;

   logic [1:0] sel_q;
   logic       ld_q, rd_q, wr_q, push_q, pop_q, qshift_q, show_q;
   logic       rst_xy_q, rst_stack_q, rst_queue_q, busy_q, done_q, fail_q;

   assign steps_inc = (steps_q == '1) ? steps_q : steps_q + 1'b1;
   assign limit_hit = (steps_inc >= StepMax);

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      steps_d = steps_q;
      hold_d  = hold_q;
      case (state_q)
         StIdle, StDone, StFail: if (bus.start) state_d = StInit;
         StInit: begin
            dir_d   = 2'd0;
            steps_d = '0;
            state_d = StMark;
         end
         StMark: state_d = StCheck;
         StCheck: begin
            if (bus.end_pos) begin
               state_d = StShowLd;
            end else begin
               dir_d   = 2'd0;
               state_d = StProbe;
            end
         end
         // cout and mem_blk both reject the candidate; no separate priority path needed.
         StProbe: state_d = (bus.cout || bus.mem_blk) ? StNext : StAdvance;
         StAdvance: begin
            steps_d = steps_inc;
            state_d = limit_hit ? StFail : StMark;
         end
         StNext: begin
            if (dir_q == 2'd3) begin
               state_d = StBack;
            end else begin
               dir_d   = dir_q + 2'd1;
               state_d = StProbe;
            end
         end
         StBack: state_d = bus.s_empty ? StFail : StBmove;
         StBmove: begin
            steps_d = steps_inc;
            if (limit_hit) begin
               state_d = StFail;
            end else if (bus.dir_out == 2'd3) begin
               state_d = StBack;
            end else begin
               dir_d   = bus.dir_out + 2'd1;
               state_d = StProbe;
            end
         end
         StShowLd: begin
            hold_d  = '0;
            state_d = bus.s_empty ? StDone : StShowCur;
         end
         StShowCur: begin
            if (hold_q == HoldLast) begin
               state_d = StShowSh;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         StShowSh: state_d = StShowChk;
         StShowChk: begin
            hold_d  = '0;
            state_d = bus.queue_done ? StDone : StShowCur;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         dir_q       <= '0;
         steps_q     <= '0;
         hold_q      <= '0;
         sel_q       <= '0;
         ld_q        <= 1'b0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         push_q      <= 1'b0;
         pop_q       <= 1'b0;
         qshift_q    <= 1'b0;
         show_q      <= 1'b0;
         rst_xy_q    <= 1'b0;
         rst_stack_q <= 1'b0;
         rst_queue_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         steps_q     <= steps_d;
         hold_q      <= hold_d;
         sel_q       <= (state_d inside {StProbe, StAdvance}) ? dir_d : 2'b00;
         ld_q        <= state_d inside {StAdvance, StBmove};
         rd_q        <= (state_d == StProbe);
         wr_q        <= (state_d == StMark);
         push_q      <= (state_d == StAdvance);
         // The stack is stable across the edge into BACK, so its empty flag is already final.
         pop_q       <= (state_d == StBack) && !bus.s_empty;
         qshift_q    <= (state_d == StShowSh);
         show_q      <= (state_d == StShowCur);
         rst_xy_q    <= (state_d == StInit);
         rst_stack_q <= (state_d == StInit);
         rst_queue_q <= (state_d == StInit) || (state_d == StShowLd);
         busy_q      <= !(state_d inside {StIdle, StDone, StFail});
         done_q      <= (state_d == StDone);
         fail_q      <= (state_d == StFail);
      end
   end

   // The popped or replayed direction only arrives from the stack during the state that uses it.
   always_comb begin
      case (state_q)
         StBmove:   bus.sel = ~bus.dir_out;
         StShowCur: bus.sel = bus.dir_out;
         default:   bus.sel = sel_q;
      endcase
   end

   assign bus.ld        = ld_q;
   assign bus.rd        = rd_q;
   assign bus.wr        = wr_q;
   assign bus.push      = push_q;
   assign bus.pop       = pop_q;
   assign bus.qshift    = qshift_q;
   assign bus.show_move = show_q;
   assign bus.rst_xy    = rst_xy_q;
   assign bus.rst_stack = rst_stack_q;
   assign bus.rst_queue = rst_queue_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.fail      = fail_q;
endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Bench for maze_solver_ctrl: a behavioural datapath per DUT and a plain DFS reference solver.
module tb_maze_solver_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_v [2] = '{1'b0, 1'b0};
   logic wall [0:255];

   wire         done_v [2], fail_v [2];
   wire [14:0]  outs_v [2];
   wire [31:0]  push_v [2], pop_v [2], probe_v [2], pulse_v [2], showc_v [2];
   wire [1:0]   rev_v [2];
   wire [511:0] rep_v [2];

   int checks   = 0;
   int failures = 0;

   bit         ref_ok;
   int         ref_pushes, ref_pops, ref_probes;
   logic [1:0] ref_path [$];

   always #5 clk = ~clk;

   // Instance 0: default step limit, two-cycle replay hold. Instance 1: step limit of 8.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      maze_solver_ctrl_if bus ();

      logic [3:0]   x = '0, y = '0, nx, ny;
      logic [1:0]   stk [0:255];
      logic         vis [0:255];
      logic [1:0]   dout = '0;
      logic [7:0]   addr;
      int           sp = 0, qp = 0;
      int           push_cnt = 0, pop_cnt = 0, probe_cnt = 0, pulse_cnt = 0, show_cyc = 0;
      int           bm_cnt = 0;
      logic [1:0]   first_rev = '0;
      logic [511:0] rep = '0;
      logic         show_prev = 1'b0;

      maze_solver_ctrl #(
         .STEP_LIMIT (g == 0 ? 4096 : 8),
         .SHOW_HOLD  (g == 0 ? 2 : 1)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      always_comb begin
         nx = x;
         ny = y;
         case (bus.sel)
            2'b00:   ny = y - 4'd1;
            2'b01:   nx = x + 4'd1;
            2'b10:   nx = x - 4'd1;
            default: ny = y + 4'd1;
         endcase
      end

      assign bus.start      = start_v[g];
      assign bus.cout       = (bus.sel == 2'b00 && y == 4'd0) || (bus.sel == 2'b01 && x == 4'd15) ||
                              (bus.sel == 2'b10 && x == 4'd0) || (bus.sel == 2'b11 && y == 4'd15);
      assign addr           = bus.rd ? {ny, nx} : {y, x};
      assign bus.mem_blk    = wall[addr] | vis[addr];
      assign bus.end_pos    = (x == 4'd15) && (y == 4'd15);
      assign bus.s_empty    = (sp == 0);
      assign bus.queue_done = (qp == sp);
      assign bus.dir_out    = dout;

      always @(posedge clk) begin
         if (bus.rst_xy) begin
            x <= '0;
            y <= '0;
            for (int i = 0; i < 256; i++) vis[i] <= 1'b0;
            push_cnt  <= 0;
            pop_cnt   <= 0;
            probe_cnt <= 0;
            pulse_cnt <= 0;
            show_cyc  <= 0;
            bm_cnt    <= 0;
            first_rev <= '0;
            rep       <= '0;
         end else begin
            if (bus.ld) begin
               x <= nx;
               y <= ny;
            end
            if (bus.wr) vis[{y, x}] <= 1'b1;
            if (bus.push) push_cnt <= push_cnt + 1;
            if (bus.pop) pop_cnt <= pop_cnt + 1;
            if (bus.rd) probe_cnt <= probe_cnt + 1;
            if (bus.show_move) show_cyc <= show_cyc + 1;
            if (bus.show_move && !show_prev) begin
               rep[2*pulse_cnt +: 2] <= bus.sel;
               pulse_cnt <= pulse_cnt + 1;
            end
            if (bus.ld && !bus.push) begin
               if (bm_cnt == 0) first_rev <= bus.sel;
               bm_cnt <= bm_cnt + 1;
            end
         end
         show_prev <= bus.show_move;
         if (bus.rst_stack) begin
            sp <= 0;
         end else if (bus.push) begin
            stk[sp] <= bus.sel;
            sp      <= sp + 1;
         end else if (bus.pop) begin
            dout <= stk[sp-1];
            sp   <= sp - 1;
         end
         if (bus.rst_queue) begin
            qp   <= 0;
            dout <= stk[0];
         end else if (bus.qshift) begin
            qp   <= qp + 1;
            dout <= stk[qp+1];
         end
      end

      assign done_v[g]  = bus.done;
      assign fail_v[g]  = bus.fail;
      assign outs_v[g]  = {bus.sel, bus.ld, bus.rd, bus.wr, bus.push, bus.pop, bus.qshift,
                           bus.show_move, bus.rst_xy, bus.rst_stack, bus.rst_queue, bus.busy,
                           bus.done, bus.fail};
      assign push_v[g]  = push_cnt;
      assign pop_v[g]   = pop_cnt;
      assign probe_v[g] = probe_cnt;
      assign pulse_v[g] = pulse_cnt;
      assign showc_v[g] = show_cyc;
      assign rev_v[g]   = first_rev;
      assign rep_v[g]   = rep;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void step_of(input int k, input int cx, input int cy,
                                   output int nx, output int ny);
      nx = cx;
      ny = cy;
      case (k)
         0:       ny = cy - 1;
         1:       nx = cx + 1;
         2:       nx = cx - 1;
         default: ny = cy + 1;
      endcase
   endfunction

   // Reference DFS: try up/right/left/down in order, walk back along the path when stuck.
   task automatic ref_solve(input int limit);
      bit         seen [256];
      int         cx, cy, nx, ny, d, steps;
      bit         moved;
      logic [1:0] p;
      foreach (seen[i]) seen[i] = 1'b0;
      ref_path.delete();
      ref_ok     = 1'b0;
      ref_pushes = 0;
      ref_pops   = 0;
      ref_probes = 0;
      cx = 0; cy = 0; d = 0; steps = 0;
      seen[0] = 1'b1;
      forever begin
         if (cx == 15 && cy == 15) begin
            ref_ok = 1'b1;
            return;
         end
         moved = 1'b0;
         for (int k = d; k < 4 && !moved; k++) begin
            ref_probes++;
            step_of(k, cx, cy, nx, ny);
            if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16) begin
               if (!wall[ny*16+nx] && !seen[ny*16+nx]) begin
                  ref_path.push_back(2'(k));
                  seen[ny*16+nx] = 1'b1;
                  cx = nx;
                  cy = ny;
                  moved = 1'b1;
                  ref_pushes++;
               end
            end
         end
         if (moved) begin
            d = 0;
         end else begin
            if (ref_path.size() == 0) return;
            p = ref_path.pop_back();
            step_of(3 - int'(p), cx, cy, nx, ny);
            cx = nx;
            cy = ny;
            ref_pops++;
            d = int'(p) + 1;
         end
         steps++;
         if (steps >= limit) return;
      end
   endtask

   task automatic fill_maze(input logic v);
      for (int i = 0; i < 256; i++) wall[i] = v;
   endtask

   task automatic open_cell(input int cx, input int cy);
      wall[cy*16+cx] = 1'b0;
   endtask

   task automatic build_corridor();
      fill_maze(1'b1);
      for (int i = 0; i < 16; i++) begin
         open_cell(i, 0);
         open_cell(15, i);
      end
   endtask

   task automatic pulse_start(input int g);
      @(negedge clk);
      start_v[g] = 1'b1;
      @(negedge clk);
      start_v[g] = 1'b0;
   endtask

   task automatic wait_end(input int g, input string tag);
      int c = 0;
      while (!(done_v[g] || fail_v[g]) && c < 20000) begin
         @(negedge clk);
         c++;
      end
      check({tag, " finish"}, 32'(c < 20000), 32'd1);
   endtask

   task automatic check_run(input int g, input string tag);
      int mism = 0;
      check({tag, " done"}, 32'(done_v[g]), 32'(ref_ok));
      check({tag, " fail"}, 32'(fail_v[g]), 32'(!ref_ok));
      check({tag, " busy"}, 32'(outs_v[g][2]), 32'd0);
      check({tag, " pushes"}, push_v[g], 32'(ref_pushes));
      check({tag, " pops"}, pop_v[g], 32'(ref_pops));
      if (ref_ok) begin
         check({tag, " pulses"}, pulse_v[g], 32'(ref_path.size()));
         for (int i = 0; i < ref_path.size(); i++) begin
            if (rep_v[g][2*i +: 2] !== ref_path[i]) mism++;
         end
         check({tag, " replay mismatches"}, 32'(mism), 32'd0);
      end
   endtask

   initial begin
      int c;
      fill_maze(1'b1);
      open_cell(0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset outs dut0", 32'(outs_v[0]), 32'd0);
      check("reset outs dut1", 32'(outs_v[1]), 32'd0);

      // Corridor: 15 moves right, 15 moves down.
      build_corridor();
      ref_solve(4096);
      pulse_start(0);
      wait_end(0, "corridor");
      check_run(0, "corridor");
      check("corridor push const", push_v[0], 32'd30);
      check("corridor pulse const", pulse_v[0], 32'd30);
      check("corridor hold cycles", showc_v[0], 32'd60);
      check("corridor first sel", 32'(rep_v[0][1:0]), 32'd1);
      check("corridor 16th sel", 32'(rep_v[0][31:30]), 32'd3);

      // start in DONE restarts and clears done; start while busy is ignored.
      pulse_start(0);
      check("done restart done", 32'(outs_v[0][1]), 32'd0);
      check("done restart clears", 32'(outs_v[0][5:3]), 32'd7);
      c = 0;
      while (!(outs_v[0][10] && push_v[0] >= 5) && c < 2000) begin
         @(negedge clk);
         c++;
      end
      check("busy reach mark", 32'(c < 2000), 32'd1);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      check("busy start no init", 32'(outs_v[0][5]), 32'd0);
      check("busy start busy", 32'(outs_v[0][2]), 32'd1);
      wait_end(0, "busy start");
      check_run(0, "busy start");

      // Walled start: both reachable neighbours blocked.
      fill_maze(1'b1);
      open_cell(0, 0);
      ref_solve(4096);
      pulse_start(0);
      wait_end(0, "walled");
      check_run(0, "walled");
      check("walled fail const", 32'(fail_v[0]), 32'd1);
      check("walled probes", probe_v[0], 32'd4);
      check("walled push const", push_v[0], 32'd0);

      // Dead-end branch along row 0 up to (3,0), real path down column 0 then row 15.
      fill_maze(1'b1);
      for (int i = 0; i < 4; i++) open_cell(i, 0);
      for (int i = 0; i < 16; i++) begin
         open_cell(0, i);
         open_cell(i, 15);
      end
      ref_solve(4096);
      pulse_start(0);
      wait_end(0, "deadend");
      check_run(0, "deadend");
      check("deadend pops const", pop_v[0], 32'd3);
      check("deadend reverse sel", 32'(rev_v[0]), 32'd2);
      check("deadend done const", 32'(done_v[0]), 32'd1);

      // Reset while probing, then a clean restart.
      build_corridor();
      pulse_start(0);
      c = 0;
      while (!outs_v[0][11] && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("reach probe", 32'(c < 200), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid reset outs", 32'(outs_v[0]), 32'd0);
      rst = 1'b0;
      pulse_start(0);
      check("post reset init clears", 32'(outs_v[0][5:3]), 32'd7);
      ref_solve(4096);
      wait_end(0, "post reset");
      check_run(0, "post reset");

      // Step limit of 8 on the corridor.
      ref_solve(8);
      pulse_start(1);
      wait_end(1, "limit");
      check_run(1, "limit");
      check("limit push const", push_v[1], 32'd8);
      check("limit fail const", 32'(fail_v[1]), 32'd1);

      // Random mazes.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 256; i++) wall[i] = ($urandom_range(0, 99) < 30);
         wall[0]   = 1'b0;
         wall[255] = 1'b0;
         ref_solve(4096);
         pulse_start(0);
         wait_end(0, $sformatf("rand%0d", r));
         check_run(0, $sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/maze_solver_ctrl.md
Name: maze_solver_ctrl

Overview:
- FSM sequencer for the maze-solver datapath: 4-bit X/Y position registers, direction-indexed inc/dec muxes, a 2-bit direction stack with queue-replay mode, and an end-position comparator at (15,15).
- Runs a depth-first search from (0,0) to (15,15) against an external 16x16 maze memory (combinational read), marking visited cells as it goes.
- Replays the found path one move at a time through the queue port.
- Reports done, or fail when no path exists or the step limit is exceeded.

Parameters:
- STEP_LIMIT, 4096: maximum ADVANCE+BMOVE steps before forced fail.
- SHOW_HOLD, 1: cycles each replayed move stays presented (show_move high) before the queue shift; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin solve; sampled only in IDLE, DONE or FAIL.
- mem_blk  in  1  maze memory read of the addressed cell: 1 = wall or visited. Valid in the same cycle as the address.
- end_pos  in  1  datapath at (15,15).
- s_empty  in  1  direction stack empty.
- cout  in  1  carry/borrow of the selected direction (step leaves the grid).
- queue_done  in  1  replay count equals stack depth.
- dir_out  in  2  popped direction; valid the cycle after pop.
- sel  out  2  direction: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1).
- ld  out  1  load X/Y from the direction mux.
- rd  out  1  present the candidate (next) position to memory instead of the current position.
- wr  out  1  write visited=1 at the current position.
- push, pop  out  1  stack operations.
- qshift, show_move  out  1  replay controls.
- rst_xy, rst_stack, rst_queue  out  1  datapath clears.
- busy  out  1  high in every state except IDLE, DONE, FAIL.
- done, fail  out  1  sticky status flags.

Behaviour:
- Reset: state=IDLE; all outputs 0; dir counter, step counter and hold counter cleared.
- Reset mid-operation returns to IDLE on the next edge. No datapath clear is issued then; INIT performs it on the next start.
- All outputs are Moore-decoded from the state and registers; none depend combinationally on start.
- IDLE/DONE/FAIL: if start=1 → INIT; done and fail are cleared on that transition. start in any other state is ignored.
- INIT (1 cycle): rst_xy=rst_stack=rst_queue=1; dir=0; steps=0 → MARK.
- MARK: wr=1, rd=0 → CHECK.
- CHECK: end_pos=1 → SHOW_LD; else dir=0 → PROBE.
- PROBE: sel=dir, rd=1.
  - cout=1 or mem_blk=1 → NEXT.
  - Otherwise → ADVANCE.
- ADVANCE: sel=dir, ld=1, push=1 (pushes dir); steps+1 → MARK.
- NEXT: dir==3 → BACK; else dir+1 → PROBE.
- BACK: s_empty=1 → FAIL; else pop=1 → BMOVE.
- BMOVE: latch p=dir_out; sel=~p (reverse move), ld=1; steps+1.
  - p==3 → BACK.
  - Else dir=p+1 → PROBE.
- Step limit: if steps reaches STEP_LIMIT on an ADVANCE or BMOVE, the next state is FAIL instead.
- SHOW_LD: rst_queue=1; s_empty=1 → DONE; else → SHOW_CUR.
- SHOW_CUR: show_move=1 for SHOW_HOLD cycles (hold counter) → SHOW_SH.
- SHOW_SH: qshift=1 → SHOW_CHK.
- SHOW_CHK: queue_done=1 → DONE; else → SHOW_CUR.
- DONE: done=1. FAIL: fail=1. Both are held until the next start.
- Counter widths: dir is 2 bits with no wrap (NEXT guards it); steps is clog2(STEP_LIMIT)+1 bits, saturating.
- Simultaneous events: end_pos is checked only in CHECK; cout has priority over mem_blk (both route to NEXT).

Test Plan:
- Corridor maze: free cells are row y=0 (x 0..15) plus column x=15 (y 0..15) → 30 pushes, 30 show_move pulses; replay sel = 15×01 then 15×11; done=1, fail=0.
- Walled start: (1,0) and (0,1) blocked → 4 PROBEs, BACK with s_empty=1 → fail=1, done=0, push count 0.
- Dead end: branch to (3,0) closed with a wall → pops with reverse sel observed (01 reversed to 10); search resumes at the next direction and finally reaches done.
- rst asserted during PROBE → next cycle IDLE, all outputs 0. A following start issues rst_xy/rst_stack/rst_queue in INIT.
- STEP_LIMIT=8 on the corridor maze → fail=1 after the 8th ADVANCE; busy=0.
- start pulsed while busy=1 → no state change. start in DONE → INIT, done cleared.
